// File: rtl/fft64_frame_feeder_pkg.sv
// Shared FFT64 frame configuration and the feeder's read-side state encoding.
package fft64_frame_feeder_pkg;
  localparam int FRAME_LEN = 64;
  localparam int AW        = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, START_ST, STREAM, WAIT} rd_state_e;
endpackage

// File: rtl/fft64_pingpong_ram.sv
// Two 64-entry banks of packed {re,im}; the bank is the address MSB.
// The read register doubles as the DR/DI output register, so it is zero whenever no read is issued.
module fft64_pingpong_ram
  import fft64_frame_feeder_pkg::*;
#(
  parameter int nb = 16
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            we,
  input  logic [AW:0]     waddr,
  input  logic [2*nb-1:0] wdata,
  input  logic            re,
  input  logic [AW:0]     raddr,
  output logic [2*nb-1:0] rdata
);
  logic [2*nb-1:0] mem [0:2*FRAME_LEN-1];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk)
    if (clr)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else         rdata <= '0;
endmodule

// File: rtl/fft64_frame_feeder.sv
// Buffers a valid/ready sample stream into ping-pong banks and plays whole frames
// to the FFT core as START + gap-free ED runs.
module fft64_frame_feeder
  import fft64_frame_feeder_pkg::*;
#(
  parameter int nb = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VLD,
  output logic          IN_RDY,
  input  logic [nb-1:0] IN_DR,
  input  logic [nb-1:0] IN_DI,
  input  logic          RESTART,
  input  logic [3:0]    SHIFT_IN,
  output logic          START,
  output logic          ED,
  output logic [nb-1:0] DR,
  output logic [nb-1:0] DI,
  output logic [3:0]    SHIFT,
  output logic          GAP,
  output logic [15:0]   FRAMES
);
  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

  logic            clr;
  logic [1:0]      full;
  logic            wbank, rbank;
  logic [AW-1:0]   waddr, raddr;
  logic            wr, ren, rd_last;
  logic [2*nb-1:0] rdata;
  rd_state_e       state, nxt;

  assign clr    = RST | RESTART;
  assign IN_RDY = !clr && !full[wbank];
  assign wr     = IN_VLD && IN_RDY;

  always_ff @(posedge CLK)
    if (clr) begin
      wbank <= 1'b0;
      waddr <= '0;
    end else if (wr) begin
      waddr <= waddr + 1'b1;
      if (waddr == LAST) wbank <= ~wbank;
    end

  // Writer only touches a non-full bank, reader only clears a full one: never the same bit.
  always_ff @(posedge CLK)
    if (clr) full <= '0;
    else begin
      if (wr && waddr == LAST) full[wbank] <= 1'b1;
      if (rd_last)             full[rbank] <= 1'b0;
    end

  always_ff @(posedge CLK)
    if (clr) state <= IDLE;
    else     state <= nxt;

  // State mirrors what the outputs show this cycle; nxt is what they show next cycle.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (full[rbank]) nxt = START_ST;
      START_ST: nxt = STREAM;
      STREAM:   nxt = (raddr != '0 || full[rbank]) ? STREAM : WAIT;
      WAIT:     if (full[rbank]) nxt = STREAM;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    ren     = (nxt == STREAM);
    rd_last = ren && (raddr == LAST);
  end

  // GAP marks a real inter-frame hole: only a WAIT that ends in another frame counts.
  always_ff @(posedge CLK)
    if (clr) begin
      rbank <= 1'b0;
      raddr <= '0;
      START <= 1'b0;
      ED    <= 1'b0;
      GAP   <= 1'b0;
      SHIFT <= '0;
      if (RST) FRAMES <= '0;
    end else begin
      START <= (nxt == START_ST);
      ED    <= (nxt == START_ST) || (nxt == STREAM);
      if (state == WAIT && nxt == STREAM) GAP <= 1'b1;
      if (state == START_ST) SHIFT <= SHIFT_IN;
      if (ren) raddr <= raddr + 1'b1;
      if (rd_last) begin
        rbank  <= ~rbank;
        FRAMES <= FRAMES + 1'b1;
      end
    end

  fft64_pingpong_ram #(.nb(nb)) u_ram (
    .clk   (CLK),
    .clr   (clr),
    .we    (wr),
    .waddr ({wbank, waddr}),
    .wdata ({IN_DR, IN_DI}),
    .re    (ren),
    .raddr ({rbank, raddr}),
    .rdata (rdata)
  );

  assign DR = rdata[2*nb-1:nb];
  assign DI = rdata[nb-1:0];
endmodule

// File: tb/tb_fft64_frame_feeder.sv
// Directed bench for fft64_frame_feeder: reset, single/back-to-back/gapped frames,
// backpressure and mid-frame RESTART.
module tb_fft64_frame_feeder;
  localparam int NB = 16;

  logic          CLK = 1'b0;
  logic          RST, IN_VLD, IN_RDY, RESTART, START, ED, GAP;
  logic [NB-1:0] IN_DR, IN_DI, DR, DI;
  logic [3:0]    SHIFT_IN, SHIFT;
  logic [15:0]   FRAMES;

  fft64_frame_feeder #(.nb(NB)) dut (
    .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY), .IN_DR(IN_DR), .IN_DI(IN_DI),
    .RESTART(RESTART), .SHIFT_IN(SHIFT_IN), .START(START), .ED(ED), .DR(DR), .DI(DI),
    .SHIFT(SHIFT), .GAP(GAP), .FRAMES(FRAMES)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: records what the FFT side sees, sampled at the falling edge.
  logic [2*NB-1:0] obs[$];
  logic [2*NB-1:0] exp_q[$];
  logic mon_clr = 1'b0;
  logic prev_ed = 1'b0;
  int nstart = 0, nrise = 0, run = 0, maxrun = 0, start_cyc = -1, data_cyc = -1;

  always @(negedge CLK) begin
    if (mon_clr) begin
      obs.delete();
      nstart = 0; nrise = 0; run = 0; maxrun = 0;
      start_cyc = -1; data_cyc = -1; prev_ed = 1'b0;
    end else begin
      if (START === 1'b1) begin
        nstart++;
        if (start_cyc < 0) start_cyc = cyc;
      end
      if (ED === 1'b1 && START !== 1'b1) begin
        obs.push_back({DR, DI});
        if (data_cyc < 0) data_cyc = cyc;
      end
      if (ED === 1'b1) begin
        run++;
        if (run > maxrun) maxrun = run;
        if (!prev_ed) nrise++;
      end else run = 0;
      prev_ed = (ED === 1'b1);
    end
  end

  int hs_cyc = 0;
  int first_stall = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge CLK);
    #1 mon_clr = 1'b0;
    exp_q.delete();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_restart();
    RESTART = 1'b1;
    @(posedge CLK);
    #1 RESTART = 1'b0;
  endtask

  // Offers n samples DR=base+k, DI=-(base+k), IN_VLD held high until all are accepted.
  task automatic send(input int n, input int base);
    int k = 0;
    int guard = 0;
    logic rdy;
    while (k < n && guard < 2000) begin
      IN_VLD = 1'b1;
      IN_DR  = NB'(base + k);
      IN_DI  = NB'(-(base + k));
      @(negedge CLK);
      rdy = IN_RDY;
      if (rdy) hs_cyc = cyc;
      else if (first_stall < 0) first_stall = k;
      @(posedge CLK);
      #1;
      if (rdy) begin
        exp_q.push_back({IN_DR, IN_DI});
        k++;
      end
      guard++;
    end
    IN_VLD = 1'b0;
    if (k != n) check("send_timeout", k, n);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      check($sformatf("%s_s%0d", tag, i), obs[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    RST = 1'b1; IN_VLD = 1'b1; RESTART = 1'b0; SHIFT_IN = 4'b0000;
    IN_DR = 16'h1234; IN_DI = 16'h5678;

    // Reset with IN_VLD high: nothing is accepted, all outputs clear.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_in_rdy_low", IN_RDY, 0);
    @(posedge CLK);
    #1 RST = 1'b0; IN_VLD = 1'b0;
    @(negedge CLK);
    check("rst_start", START, 0);
    check("rst_ed", ED, 0);
    check("rst_gap", GAP, 0);
    check("rst_frames", FRAMES, 0);
    check("rst_in_rdy", IN_RDY, 1);
    check("rst_dr", DR, 0);
    @(posedge CLK);
    #1;

    // Single frame: START two cycles after the 64th handshake, samples from the next cycle.
    clr_mon();
    send(64, 0);
    idle(80);
    check("single_nstart", nstart, 1);
    check("single_start_cyc", start_cyc, hs_cyc + 2);
    check("single_data_cyc", data_cyc, hs_cyc + 3);
    check("single_run", maxrun, 65);
    cmp_stream("single");
    check("single_frames", FRAMES, 1);
    check("single_ed_after", ED, 0);
    check("single_gap", GAP, 0);

    // Back-to-back: the START cycle plus 128 data cycles form one unbroken ED run.
    pulse_restart();
    check("restart_keeps_frames", FRAMES, 1);
    clr_mon();
    send(128, 100);
    idle(150);
    check("b2b_nstart", nstart, 1);
    check("b2b_run", maxrun, 129);
    check("b2b_nrise", nrise, 1);
    cmp_stream("b2b");
    check("b2b_frames", FRAMES, 3);
    check("b2b_gap", GAP, 0);

    // Gap: ED drops between frames, no second START, GAP set.
    pulse_restart();
    clr_mon();
    send(64, 200);
    idle(20);
    send(64, 300);
    idle(100);
    check("gap_nstart", nstart, 1);
    check("gap_nrise", nrise, 2);
    check("gap_gap", GAP, 1);
    cmp_stream("gap");
    check("gap_frames", FRAMES, 5);
    pulse_restart();
    @(negedge CLK);
    check("restart_clears_gap", GAP, 0);
    check("restart_frames", FRAMES, 5);
    @(posedge CLK);
    #1;

    // Backpressure: both banks fill after 128 samples, then stall until bank 0 drains.
    clr_mon();
    first_stall = -1;
    send(192, 400);
    idle(150);
    check("bp_first_stall", first_stall, 128);
    check("bp_nstart", nstart, 1);
    cmp_stream("bp");
    check("bp_frames", FRAMES, 8);

    // RESTART while sample 30 is on the bus; a pending partial frame is discarded.
    pulse_restart();
    clr_mon();
    send(64, 500);
    send(10, 600);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK);
      if (ED === 1'b1 && DR === NB'(530)) found = 1'b1;
    end
    check("rs_found_s30", found, 1);
    RESTART = 1'b1;
    SHIFT_IN = 4'b0110;
    #1;
    check("rs_in_rdy", IN_RDY, 0);
    @(posedge CLK);
    #1 RESTART = 1'b0;
    @(negedge CLK);
    check("rs_ed_next", ED, 0);
    check("rs_dr_next", DR, 0);
    check("rs_frames_kept", FRAMES, 8);
    @(posedge CLK);
    #1;
    clr_mon();
    idle(70);
    check("rs_flushed_nstart", nstart, 0);
    send(64, 700);
    idle(80);
    check("rs_nstart", nstart, 1);
    check("rs_shift", SHIFT, 4'b0110);
    cmp_stream("rs");
    check("rs_frames", FRAMES, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
